// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked W-bit ALU with iterative shifts and optional iterative multiply
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier for opcode 11.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       OPCODE,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             ovf,
    output logic             sign,
    output logic             negative,
    output logic             zero
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [SW:0]      count;
    logic             flag_en;
    logic             cin;
    logic             cin_msb;
    logic             fast_arith;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] fast_s;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     part;

    // Accumulator holds {partial product, remaining multiplier bits}.
    always_comb begin
        part    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_nxt = {part, acc[WIDTH-1:1]};
    end
`endif

    always_comb begin
        cin        = (OPCODE == 4'd1);
        bb         = cin ? ~b : b;
        sum_ext    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        cin_msb    = a[WIDTH-1] ^ bb[WIDTH-1] ^ sum_ext[WIDTH-1];
        fast_arith = (OPCODE <= 4'd1);
        case (OPCODE)
            4'd0, 4'd1: fast_s = sum_ext[WIDTH-1:0];
            4'd2:       fast_s = a & b;
            4'd3:       fast_s = a | b;
            4'd4:       fast_s = a ^ b;
            4'd5:       fast_s = {{(WIDTH-1){1'b0}}, a > b};
            4'd6:       fast_s = a << 1;
            4'd7:       fast_s = a >> 1;
            default:    fast_s = '0;
        endcase
    end

    always_comb begin
        case (op_q)
            4'd8:    work_nxt = work << 1;
            4'd9:    work_nxt = work >> 1;
            default: work_nxt = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

    assign inReady  = (state == IDLE) && !rst;
    assign outValid = (state == DONE);
    // Reserved opcodes clear flag_en so that even zero reads 0 for them.
    assign negative = flag_en & s[WIDTH-1];
    assign zero     = flag_en & (s == '0);
    assign sign     = ovf ^ negative;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            work    <= '0;
            count   <= '0;
            s       <= '0;
            cOut    <= 1'b0;
            ovf     <= 1'b0;
            flag_en <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc     <= '0;
            mcand   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        op_q <= OPCODE;
                        if (OPCODE >= 4'd8 && OPCODE <= 4'd10) begin
                            work  <= a;
                            count <= {1'b0, b[SW-1:0]};
                            if (b[SW-1:0] == '0) begin
                                state   <= DONE;
                                s       <= a;
                                cOut    <= 1'b0;
                                ovf     <= 1'b0;
                                flag_en <= 1'b1;
                            end else begin
                                state <= BUSY;
                            end
                        end
`ifdef SEQ_ALU_MUL_EN
                        else if (OPCODE == 4'd11) begin
                            acc   <= {{WIDTH{1'b0}}, b};
                            mcand <= a;
                            count <= (SW+1)'(WIDTH);
                            state <= BUSY;
                        end
`endif
                        else begin
                            state   <= DONE;
                            s       <= fast_s;
                            cOut    <= fast_arith & sum_ext[WIDTH];
                            ovf     <= fast_arith & (cin_msb ^ sum_ext[WIDTH]);
                            flag_en <= (OPCODE <= 4'd7);
                        end
                    end
                end
                BUSY: begin
                    count <= count - {{SW{1'b0}}, 1'b1};
                    work  <= work_nxt;
`ifdef SEQ_ALU_MUL_EN
                    acc   <= acc_nxt;
`endif
                    // The last step lands directly in DONE so latency is steps + 1.
                    if (count == {{SW{1'b0}}, 1'b1}) begin
                        state   <= DONE;
                        ovf     <= 1'b0;
                        flag_en <= 1'b1;
`ifdef SEQ_ALU_MUL_EN
                        if (op_q == 4'd11) begin
                            s    <= acc_nxt[WIDTH-1:0];
                            cOut <= |acc_nxt[2*WIDTH-1:WIDTH];
                        end else
`endif
                        begin
                            s    <= work_nxt;
                            cOut <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (outReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=16), honours SEQ_ALU_MUL_EN
module tb_seq_alu;
    localparam int W = 16;
`ifdef SEQ_ALU_MUL_EN
    localparam int LAST_OP = 11;
`else
    localparam int LAST_OP = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [3:0]   OPCODE;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] s;
    logic         cOut;
    logic         ovf;
    logic         sign;
    logic         negative;
    logic         zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] s;
        logic        c, o, n, sg, z;
        int          lat;
    } exp_t;

    exp_t exp_q;
    logic exp_valid = 1'b0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .OPCODE(OPCODE), .a(a), .b(b), .outValid(outValid), .outReady(outReady),
        .s(s), .cOut(cOut), .ovf(ovf), .sign(sign), .negative(negative), .zero(zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        int          r, sr, k;
        logic [31:0] p;
        k     = int'(y[3:0]);
        e.s   = 16'h0;
        e.c   = 1'b0;
        e.o   = 1'b0;
        e.lat = 1;
        p     = 32'h0;
        case (op)
            4'd0: begin
                r   = int'(x) + int'(y);
                sr  = int'($signed(x)) + int'($signed(y));
                e.s = r[15:0];
                e.c = (r > 65535);
                e.o = (sr > 32767) || (sr < -32768);
            end
            4'd1: begin
                r   = int'(x) - int'(y);
                sr  = int'($signed(x)) - int'($signed(y));
                e.s = r[15:0];
                e.c = (x >= y);
                e.o = (sr > 32767) || (sr < -32768);
            end
            4'd2: e.s = x & y;
            4'd3: e.s = x | y;
            4'd4: e.s = x ^ y;
            4'd5: e.s = (x > y) ? 16'd1 : 16'd0;
            4'd6: e.s = x << 1;
            4'd7: e.s = x >> 1;
            4'd8:  begin e.s = x << k;            e.lat = k + 1; end
            4'd9:  begin e.s = x >> k;            e.lat = k + 1; end
            4'd10: begin e.s = $signed(x) >>> k;  e.lat = k + 1; end
`ifdef SEQ_ALU_MUL_EN
            4'd11: begin
                p     = 32'(x) * 32'(y);
                e.s   = p[15:0];
                e.c   = (p[31:16] != 16'h0);
                e.lat = 17;
            end
`endif
            default: e.s = 16'h0;
        endcase
        if (int'(op) <= LAST_OP) begin
            e.n  = e.s[15];
            e.sg = e.o ^ e.n;
            e.z  = (e.s == 16'h0);
        end else begin
            e.n  = 1'b0;
            e.sg = 1'b0;
            e.z  = 1'b0;
        end
        return e;
    endfunction

    // Whenever a result is presented it must match the model of the pending op.
    always @(negedge clk) begin
        if (!rst && outValid) begin
            if (!exp_valid) begin
                chk("spurious_out_valid", 32'(outValid), 32'h0);
            end else begin
                chk("s", 32'(s), 32'(exp_q.s));
                chk("c_out", 32'(cOut), 32'(exp_q.c));
                chk("ovf", 32'(ovf), 32'(exp_q.o));
                chk("negative", 32'(negative), 32'(exp_q.n));
                chk("sign", 32'(sign), 32'(exp_q.sg));
                chk("zero", 32'(zero), 32'(exp_q.z));
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] x,
                          input logic [15:0] y, input int stall, input int want_lat,
                          input logic [15:0] want_s);
        int lat;
        @(negedge clk);
        chk({name, "_in_ready"}, 32'(inReady), 32'h1);
        exp_q     = model(op, x, y);
        exp_valid = 1'b1;
        OPCODE    = op;
        a         = x;
        b         = y;
        inValid   = 1'b1;
        outReady  = (stall == 0);
        @(posedge clk);
        #1;
        // Keep inValid asserted with garbage: it must be ignored until IDLE.
        OPCODE = 4'($urandom);
        a      = 16'($urandom);
        b      = 16'($urandom);
        lat    = 1;
        @(negedge clk);
        while (!outValid && lat < 40) begin
            chk({name, "_busy_in_ready"}, 32'(inReady), 32'h0);
            lat++;
            @(negedge clk);
        end
        inValid = 1'b0;
        chk({name, "_latency"}, lat, want_lat);
        chk({name, "_model_latency"}, lat, exp_q.lat);
        chk({name, "_s_literal"}, 32'(s), 32'(want_s));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, "_held_valid"}, 32'(outValid), 32'h1);
            chk({name, "_held_in_ready"}, 32'(inReady), 32'h0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1 exp_valid = 1'b0;
        @(negedge clk);
        chk({name, "_consumed_valid"}, 32'(outValid), 32'h0);
        chk({name, "_consumed_in_ready"}, 32'(inReady), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        OPCODE   = 4'd0;
        a        = 16'h0;
        b        = 16'h0;

        e = model(4'd0, 16'h7FFF, 16'h0001);
        chk("pin_add_s", 32'(e.s), 32'h8000);
        chk("pin_add_flags", 32'({e.c, e.o, e.n, e.sg, e.z}), 32'(5'b01100));
        e = model(4'd1, 16'h0003, 16'h0005);
        chk("pin_sub_s", 32'(e.s), 32'hFFFE);
        chk("pin_sub_flags", 32'({e.c, e.o, e.n, e.sg, e.z}), 32'(5'b00110));
        e = model(4'd1, 16'h0005, 16'h0003);
        chk("pin_sub2_c", 32'(e.c), 32'h1);
        e = model(4'd10, 16'h8000, 16'h0004);
        chk("pin_sra_s", 32'(e.s), 32'hF800);
        chk("pin_sra_lat", e.lat, 5);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(outValid), 32'h0);
        chk("reset_s", 32'(s), 32'h0);
        chk("reset_flags", 32'({cOut, ovf, sign, negative, zero}), 32'h0);
        chk("reset_in_ready_forced", 32'(inReady), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset_in_ready", 32'(inReady), 32'h1);

        run_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 0, 1, 16'h8000);
        run_op("sub_borrow", 4'd1, 16'h0003, 16'h0005, 0, 1, 16'hFFFE);
        run_op("sub_noborrow", 4'd1, 16'h0005, 16'h0003, 0, 1, 16'h0002);
        run_op("and", 4'd2, 16'hF0F0, 16'hFF00, 0, 1, 16'hF000);
        run_op("or", 4'd3, 16'h00F0, 16'h0F00, 0, 1, 16'h0FF0);
        run_op("xor_zero", 4'd4, 16'hFFFF, 16'hFFFF, 0, 1, 16'h0000);
        run_op("gt_false", 4'd5, 16'h0002, 16'h0009, 0, 1, 16'h0000);
        run_op("shl1", 4'd6, 16'h8001, 16'h0000, 0, 1, 16'h0002);
        run_op("shr1", 4'd7, 16'h8001, 16'h0000, 0, 1, 16'h4000);
        run_op("sra4", 4'd10, 16'h8000, 16'h0004, 0, 5, 16'hF800);
        run_op("sll15", 4'd8, 16'h0001, 16'h000F, 0, 16, 16'h8000);
        run_op("srl_amt_lowbits", 4'd9, 16'hF000, 16'h0014, 0, 5, 16'h0F00);
        run_op("sll_by0", 4'd8, 16'h1234, 16'h0010, 0, 1, 16'h1234);
        run_op("reserved13", 4'd13, 16'hFFFF, 16'h0001, 0, 1, 16'h0000);
`ifdef SEQ_ALU_MUL_EN
        run_op("mul_hi", 4'd11, 16'h0100, 16'h0100, 0, 17, 16'h0000);
        run_op("mul_small", 4'd11, 16'h0003, 16'h0005, 0, 17, 16'h000F);
`else
        run_op("mul_off", 4'd11, 16'h0100, 16'h0100, 0, 1, 16'h0000);
        run_op("mul_off_small", 4'd11, 16'h0003, 16'h0005, 0, 1, 16'h0000);
`endif
        run_op("gt_backpressure", 4'd5, 16'h0009, 16'h0002, 3, 1, 16'h0001);

        // Abort an SLL by 10 during its fourth BUSY cycle.
        @(negedge clk);
        exp_q     = model(4'd8, 16'h0001, 16'h000A);
        exp_valid = 1'b1;
        OPCODE    = 4'd8;
        a         = 16'h0001;
        b         = 16'h000A;
        inValid   = 1'b1;
        outReady  = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_valid = 1'b0;
        rst       = 1'b1;
        #1 chk("midop_in_ready_forced", 32'(inReady), 32'h0);
        @(posedge clk);
        #1;
        chk("midop_out_valid", 32'(outValid), 32'h0);
        chk("midop_s", 32'(s), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midop_post_in_ready", 32'(inReady), 32'h1);
        repeat (20) @(negedge clk);
        run_op("add_after_abort", 4'd0, 16'h0002, 16'h0003, 0, 1, 16'h0005);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
